spi_tx_fifo: RTL and testbench

Byte-wide transmit FIFO between the core's data-memory bus and the SPI serializer. Core stores to a fixed MMIO data address push bytes. The serializer drains them through a valid/ready handshake. A status register at a second MMIO address lets firmware poll fill level and overflow without stalling the core.

---
 rtl/spi_tx_fifo.sv | 93 +++++++++
 tb/tb_spi_tx_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo.sv
// Byte-wide first-word-fall-through transmit FIFO fed by core MMIO stores and
// drained by the SPI serializer, with a pollable status/control register.
module spi_tx_fifo #(
   parameter int          DEPTH       = 8,
   parameter logic [31:0] DATA_ADDR   = 32'h8000_0000,
   parameter logic [31:0] STATUS_ADDR = 32'h8000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_bus_addr,
   input  logic [31:0] mem_bus_data,
   input  logic        mem_bus_write_en,
   input  logic        mem_bus_read_en,
   input  logic [3:0]  mem_bus_data_mask,
   output logic [7:0]  status_data,
   output logic        status_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic push_req, ctrl_wr, flush, clr_ovf, pop, full, empty, push_ok;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign push_req = mem_bus_write_en && (mem_bus_addr == DATA_ADDR) && mem_bus_data_mask[0];
   assign ctrl_wr  = mem_bus_write_en && (mem_bus_addr == STATUS_ADDR);
   assign flush    = ctrl_wr && mem_bus_data[1];
   assign clr_ovf  = ctrl_wr && mem_bus_data[0];
   // A flush discards the head, so a same-cycle handshake is not a pop.
   assign pop      = tx_valid && tx_ready && !flush;
   assign push_ok  = push_req && (!full || pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (clr_ovf)              ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; stale entries are never visible past the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= mem_bus_data[7:0];
   end

   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : 8'h00;

   assign status_valid = mem_bus_read_en && (mem_bus_addr == STATUS_ADDR);
   assign status_data  = status_valid ? {4'(count_q), 1'b0, ovf_q, full, empty} : 8'h00;

   logic unused_bits;
   assign unused_bits = ^{mem_bus_data[31:8], mem_bus_data_mask[3:1]};

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Randomized and directed bench for spi_tx_fifo against a queue-based model.
module tb_spi_tx_fifo;

   localparam int          DEPTH = 8;
   localparam logic [31:0] DA    = 32'h8000_0000;
   localparam logic [31:0] SA    = 32'h8000_0004;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, data;
   logic        we, re, tx_ready;
   logic [3:0]  mask;
   logic [7:0]  status_data, tx_data;
   logic        status_valid, tx_valid;

   always #5 clk = ~clk;

   spi_tx_fifo #(.DEPTH(DEPTH), .DATA_ADDR(DA), .STATUS_ADDR(SA)) dut (
      .clk(clk), .rst(rst),
      .mem_bus_addr(addr), .mem_bus_data(data),
      .mem_bus_write_en(we), .mem_bus_read_en(re),
      .mem_bus_data_mask(mask),
      .status_data(status_data), .status_valid(status_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: the FIFO is just a queue of bytes plus an overflow bit.
   logic [7:0] mq[$];
   bit         movf;
   logic [7:0] last_status, last_txd;
   logic       last_txv;

   function automatic logic [7:0] mstatus();
      int n = mq.size();
      return {4'(n), 1'b0, movf, (n == DEPTH), (n == 0)};
   endfunction

   task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic rd, input logic [3:0] m, input logic rdy);
      logic       ev, sv, flush, clr, pushr, pop, wasfull;
      rst = r; addr = a; data = d; we = w; re = rd; mask = m; tx_ready = rdy;
      @(negedge clk);
      ev = (mq.size() != 0);
      sv = rd && (a == SA);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, ev});
      chk("tx_data", {24'd0, tx_data}, {24'd0, (ev ? mq[0] : 8'h00)});
      chk("status_valid", {31'd0, status_valid}, {31'd0, sv});
      chk("status_data", {24'd0, status_data}, {24'd0, (sv ? mstatus() : 8'h00)});
      last_status = status_data; last_txd = tx_data; last_txv = tx_valid;
      @(posedge clk);
      if (r) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         flush   = w && (a == SA) && d[1];
         clr     = w && (a == SA) && d[0];
         pushr   = w && (a == DA) && m[0];
         pop     = ev && rdy && !flush;
         wasfull = (mq.size() == DEPTH);
         if (flush) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (pushr) begin
               if (!wasfull || pop) mq.push_back(d[7:0]);
               else movf = 1'b1;
            end
         end
         if (clr) movf = 1'b0;
      end
      #1;
   endtask

   task automatic push(input logic [7:0] b, input logic rdy);
      step(1'b0, DA, {24'hABCDEF, b}, 1'b1, 1'b0, 4'hF, rdy);
   endtask
   task automatic rd_status(input logic rdy);
      step(1'b0, SA, 32'h0, 1'b0, 1'b1, 4'hF, rdy);
   endtask
   task automatic idle(input logic rdy);
      step(1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 4'hF, rdy);
   endtask
   task automatic ctrl(input logic [31:0] v, input logic rdy);
      step(1'b0, SA, v, 1'b1, 1'b0, 4'hF, rdy);
   endtask

   initial begin
      rst = 1'b1; addr = '0; data = '0; we = 1'b0; re = 1'b0; mask = '0; tx_ready = 1'b0;
      movf = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      rd_status(1'b0);
      chk("reset_status", {24'd0, last_status}, 32'h01);
      chk("reset_txv", {31'd0, last_txv}, 32'h0);

      push(8'hA5, 1'b0); push(8'h3C, 1'b0);
      rd_status(1'b0);
      chk("two_status", {24'd0, last_status}, 32'h20);
      chk("two_head", {24'd0, last_txd}, 32'hA5);
      idle(1'b1); chk("drain_a5", {24'd0, last_txd}, 32'hA5);
      idle(1'b1); chk("drain_3c", {24'd0, last_txd}, 32'h3C);
      idle(1'b0); chk("drained_txv", {31'd0, last_txv}, 32'h0);

      for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
      rd_status(1'b0);
      chk("ovf_status", {24'd0, last_status}, 32'h86);
      for (int i = 1; i <= 8; i++) begin
         idle(1'b1); chk("ovf_drain", {24'd0, last_txd}, 32'(i));
      end
      idle(1'b0); chk("ovf_empty", {31'd0, last_txv}, 32'h0);
      ctrl(32'h1, 1'b0);
      rd_status(1'b0);
      chk("ovf_clear", {24'd0, last_status}, 32'h01);

      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
      push(8'hFF, 1'b1);
      rd_status(1'b0);
      chk("full_pushpop", {24'd0, last_status}, 32'h82);
      for (int i = 0; i < 8; i++) idle(1'b1);
      chk("full_last", {24'd0, last_txd}, 32'hFF);

      for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 1'b0);
      ctrl(32'h2, 1'b1);
      rd_status(1'b0);
      chk("flush_txv", {31'd0, last_txv}, 32'h0);
      chk("flush_status", {24'd0, last_status}, 32'h01);

      push(8'h60, 1'b0);
      for (int i = 1; i <= 20; i++) push(8'h60 + 8'(i), 1'b1);
      idle(1'b1);
      chk("wrap_last", {24'd0, last_txd}, 32'h74);

      step(1'b0, DA, 32'h77, 1'b1, 1'b0, 4'b1110, 1'b0);
      rd_status(1'b0);
      chk("mask_ignored", {24'd0, last_status}, 32'h01);

      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
      step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      rd_status(1'b0);
      chk("rst_txv", {31'd0, last_txv}, 32'h0);
      chk("rst_status", {24'd0, last_status}, 32'h01);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, d;
         logic        w, rd, r;
         logic [3:0]  m;
         case ($urandom_range(0, 3))
            0, 3:    a = DA;
            1:       a = SA;
            default: a = 32'h8000_0008;
         endcase
         d  = $urandom;
         w  = ($urandom_range(0, 9) < 6);
         rd = ($urandom_range(0, 9) < 3);
         m  = 4'($urandom);
         if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
         if (a == SA) d[1] = ($urandom_range(0, 9) == 0);
         r  = ($urandom_range(0, 59) == 0);
         step(r, a, d, w, rd, m, 1'($urandom_range(0, 2) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
